int_sequencer: RTL and testbench

CPU-side interrupt acknowledge sequencer: the initiator for the PIC's `intr`/`inta` handshake. At an instruction boundary with interrupts enabled, it pulses `inta`, latches the PIC's vector and reads the 4-byte IVT entry at `vector*4` over the toggle-handshake memory port. It then hands the new CS:IP to the core with a one-cycle strobe. It sits between the PIC and the 286 core's execution unit; flag/CS/IP stacking is done by core microcode after `vec_valid`.

---
 rtl/int_sequencer.sv | 125 ++++++++++++
 tb/tb_int_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt acknowledge sequencer: drives the PIC intr/inta handshake, fetches the
// IVT entry for the acknowledged vector over a toggle-handshake port, and strobes CS:IP to the core.
module int_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        boundary,
  input  logic        if_flag,
  input  logic        intr,
  input  logic [7:0]  irq_vector,
  output logic        inta,
  output logic [19:0] mem_addr,
  output logic        mem_rdout,
  input  logic        mem_rdin,
  input  logic [15:0] mem_din,
  output logic        busy,
  output logic        vec_valid,
  output logic [7:0]  vector,
  output logic [15:0] new_ip,
  output logic [15:0] new_cs,
  output logic        spurious
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACK     = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_WAIT_IP = 3'd3;
  localparam logic [2:0] S_WAIT_CS = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]  r_state;
  logic        r_inta;
  logic        r_rdout;
  logic        r_vec_valid;
  logic        r_spurious;
  logic [19:0] r_addr;
  logic [7:0]  r_vector;
  logic [15:0] r_new_ip;
  logic [15:0] r_new_cs;

  logic w_start;
  logic w_echo;

  assign w_start = boundary & if_flag & intr;
  assign w_echo  = (mem_rdin == r_rdout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_inta      <= 1'b0;
      r_rdout     <= 1'b0;
      r_vec_valid <= 1'b0;
      r_spurious  <= 1'b0;
      r_addr      <= 20'd0;
      r_vector    <= 8'd0;
      r_new_ip    <= 16'd0;
      r_new_cs    <= 16'd0;
    end else begin
      r_inta      <= 1'b0;
      r_vec_valid <= 1'b0;
      r_spurious  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_inta  <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_vector <= irq_vector;
          // Vector 0 means the PIC withdrew the request after inta; no IVT fetch.
          if (irq_vector == 8'd0) begin
            r_spurious <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_addr  <= {10'b0, irq_vector, 2'b00};
            r_rdout <= ~r_rdout;
            r_state <= S_WAIT_IP;
          end
        end
        S_WAIT_IP: begin
          if (w_echo) begin
            r_new_ip <= mem_din;
            r_addr   <= r_addr + 20'd2;
            r_rdout  <= ~r_rdout;
            r_state  <= S_WAIT_CS;
          end
        end
        S_WAIT_CS: begin
          if (w_echo) begin
            r_new_cs    <= mem_din;
            r_vec_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // The DONE cycle already counts as a boundary sample so back-to-back
          // interrupts restart without an idle bubble.
          if (w_start) begin
            r_inta  <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign inta      = r_inta;
  assign mem_addr  = r_addr;
  assign mem_rdout = r_rdout;
  assign busy      = (r_state != S_IDLE);
  assign vec_valid = r_vec_valid;
  assign vector    = r_vector;
  assign new_ip    = r_new_ip;
  assign new_cs    = r_new_cs;
  assign spurious  = r_spurious;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: toggle-echo memory responder with variable latency, event
// monitor, and a cycle-level reference of the acknowledge/fetch sequence.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        boundary = 1'b0;
  logic        if_flag = 1'b0;
  logic        intr = 1'b0;
  logic [7:0]  irq_vector = 8'd0;
  logic        inta;
  logic [19:0] mem_addr;
  logic        mem_rdout;
  logic        mem_rdin;
  logic [15:0] mem_din;
  logic        busy;
  logic        vec_valid;
  logic [7:0]  vector;
  logic [15:0] new_ip;
  logic [15:0] new_cs;
  logic        spurious;

  int_sequencer dut (
    .clk(clk), .reset_n(reset_n), .boundary(boundary), .if_flag(if_flag), .intr(intr),
    .irq_vector(irq_vector), .inta(inta), .mem_addr(mem_addr), .mem_rdout(mem_rdout),
    .mem_rdin(mem_rdin), .mem_din(mem_din), .busy(busy), .vec_valid(vec_valid),
    .vector(vector), .new_ip(new_ip), .new_cs(new_cs), .spurious(spurious)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: echoes the request toggle lat cycles after seeing it.
  logic [15:0] ivt [0:511];
  int          lat = 1;
  int          r_cnt;
  logic        r_rdin;
  logic [15:0] r_din;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdin <= 1'b0;
      r_din  <= 16'd0;
      r_cnt  <= 0;
    end else if (mem_rdout != r_rdin) begin
      if (r_cnt + 1 >= lat) begin
        r_rdin <= mem_rdout;
        r_din  <= ivt[mem_addr[9:1]];
        r_cnt  <= 0;
      end else begin
        r_cnt <= r_cnt + 1;
      end
    end
  end
  assign mem_rdin = r_rdin;
  assign mem_din  = r_din;

  // Event monitor, sampled on the falling edge.
  int          inta_q[$];
  int          vv_q[$];
  int          sp_q[$];
  logic [19:0] addr_q[$];
  int          busy_cnt = 0;
  int          overlap = 0;
  logic        m_prev_rdout = 1'b0;
  logic        m_prev_rdin = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (inta) inta_q.push_back(cyc);
      if (vec_valid) vv_q.push_back(cyc);
      if (spurious) sp_q.push_back(cyc);
      if (busy) busy_cnt <= busy_cnt + 1;
      if (mem_rdout != m_prev_rdout) begin
        addr_q.push_back(mem_addr);
        if (m_prev_rdout != m_prev_rdin) overlap <= overlap + 1;
      end
    end
    m_prev_rdout <= mem_rdout;
    m_prev_rdin  <= mem_rdin;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ACK + LATCH, then two reads of (lat+1) cycles each; strobe follows.
  function automatic int exp_vv_cycle(input int e0, input int l);
    return e0 + 2 + 2 * (l + 1);
  endfunction

  task automatic run_seq(input string tag, input logic [7:0] v, input int l);
    int bi, bv, ba, bb, e0, n;
    bi = inta_q.size(); bv = vv_q.size(); ba = addr_q.size(); bb = busy_cnt;
    lat = l;
    irq_vector = v; intr = 1'b1; if_flag = 1'b1; boundary = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    boundary = 1'b0;
    n = 0;
    while (vv_q.size() == bv && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, 32'(vv_q.size() - bv), 32'd1);
    intr = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_inta_cnt"}, 32'(inta_q.size() - bi), 32'd1);
    chk({tag, "_inta_cyc"}, 32'((inta_q.size() > bi) ? inta_q[bi] : -1), 32'(e0));
    chk({tag, "_vv_cyc"}, 32'((vv_q.size() > bv) ? vv_q[bv] : -1), 32'(exp_vv_cycle(e0, l)));
    chk({tag, "_reads"}, 32'(addr_q.size() - ba), 32'd2);
    chk({tag, "_addr_ip"}, 32'((addr_q.size() > ba) ? addr_q[ba] : 20'hFFFFF), 32'(int'(v) * 4));
    chk({tag, "_addr_cs"}, 32'((addr_q.size() > ba + 1) ? addr_q[ba + 1] : 20'hFFFFF),
        32'(int'(v) * 4 + 2));
    chk({tag, "_new_ip"}, 32'(new_ip), 32'(ivt[int'(v) * 2]));
    chk({tag, "_new_cs"}, 32'(new_cs), 32'(ivt[int'(v) * 2 + 1]));
    chk({tag, "_vector"}, 32'(vector), 32'(v));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - bb), 32'(2 * l + 5));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi, bv, ba, bb, bs, e0, n;
    logic [7:0] v;
    int l;
    for (int i = 0; i < 512; i++) ivt[i] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inta", 32'(inta), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vv", 32'(vec_valid), 32'd0);
    chk("rst_spur", 32'(spurious), 32'd0);
    chk("rst_rdout", 32'(mem_rdout), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_outs", {vector, new_ip[7:0], new_cs[15:0]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic IRQ0
    ivt[16'h20 >> 1] = 16'h1234;
    ivt[16'h22 >> 1] = 16'hF000;
    run_seq("basic", 8'h08, 1);

    // Masked: no enable or no boundary
    bi = inta_q.size(); bb = busy_cnt; ba = addr_q.size();
    intr = 1'b1; if_flag = 1'b0; boundary = 1'b1;
    repeat (20) @(negedge clk);
    if_flag = 1'b1; boundary = 1'b0;
    repeat (20) @(negedge clk);
    intr = 1'b0;
    #1;
    chk("masked_inta", 32'(inta_q.size() - bi), 32'd0);
    chk("masked_busy", 32'(busy_cnt - bb), 32'd0);
    chk("masked_toggles", 32'(addr_q.size() - ba), 32'd0);
    chk("masked_rdout", 32'(mem_rdout), 32'd0);

    // Spurious: vector withdrawn after inta
    bs = sp_q.size(); bv = vv_q.size(); ba = addr_q.size();
    irq_vector = 8'h21; intr = 1'b1; if_flag = 1'b1; boundary = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    boundary = 1'b0;
    @(posedge clk); #1;
    irq_vector = 8'h00; intr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("spur_cnt", 32'(sp_q.size() - bs), 32'd1);
    chk("spur_cyc", 32'((sp_q.size() > bs) ? sp_q[bs] : -1), 32'(e0 + 2));
    chk("spur_toggles", 32'(addr_q.size() - ba), 32'd0);
    chk("spur_vv", 32'(vv_q.size() - bv), 32'd0);
    chk("spur_vector", 32'(vector), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);

    // Slow memory, highest vector
    ivt[16'h3FC >> 1] = 16'hAAAA;
    ivt[16'h3FE >> 1] = 16'h5555;
    run_seq("slow", 8'hFF, 5);

    // Randomized vectors and latencies
    for (int k = 0; k < 6; k++) begin
      v = 8'($urandom_range(1, 255));
      l = $urandom_range(1, 4);
      run_seq("rand", v, l);
    end

    // Reset while the CS read is outstanding
    bv = vv_q.size(); ba = addr_q.size();
    lat = 3;
    irq_vector = 8'h40; intr = 1'b1; if_flag = 1'b1; boundary = 1'b1;
    @(negedge clk);
    boundary = 1'b0;
    n = 0;
    while (addr_q.size() < ba + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("midrst_in_cs", 32'(addr_q.size() - ba), 32'd2);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdout", 32'(mem_rdout), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_outs", {vector, new_ip[7:0], new_cs[15:0]}, 32'd0);
    chk("midrst_flags", {29'd0, inta, vec_valid, spurious}, 32'd0);
    intr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_vv", 32'(vv_q.size() - bv), 32'd0);
    run_seq("postrst", 8'h08, 1);

    // Back-to-back with boundary held
    bi = inta_q.size(); bv = vv_q.size(); ba = addr_q.size();
    lat = 1;
    irq_vector = 8'h77; intr = 1'b1; if_flag = 1'b1; boundary = 1'b1;
    e0 = cyc + 1;
    n = 0;
    while (inta_q.size() < bi + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    boundary = 1'b0;
    n = 0;
    while (vv_q.size() < bv + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    intr = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_inta_cnt", 32'(inta_q.size() - bi), 32'd2);
    chk("b2b_inta2_cyc", 32'((inta_q.size() > bi + 1) ? inta_q[bi + 1] : -1), 32'(e0 + 7));
    chk("b2b_vv_cnt", 32'(vv_q.size() - bv), 32'd2);
    chk("b2b_vv1_cyc", 32'((vv_q.size() > bv) ? vv_q[bv] : -1), 32'(exp_vv_cycle(e0, 1)));
    chk("b2b_vv2_cyc", 32'((vv_q.size() > bv + 1) ? vv_q[bv + 1] : -1),
        32'(exp_vv_cycle(e0 + 7, 1)));
    chk("b2b_reads", 32'(addr_q.size() - ba), 32'd4);
    chk("b2b_new_cs", 32'(new_cs), 32'(ivt[16'h77 * 2 + 1]));
    chk("overlap_total", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
